// File: rtl/norm_pkg.sv
// Shared types, widths and the golden normalization function for the norm_reader slice.
package norm_pkg;

  localparam int unsigned PIX_W         = 8;
  localparam int unsigned PIX_MAX       = 255;
  localparam int unsigned DEF_FRAC_BITS = 16;
  localparam int unsigned DEF_RECIP_W   = PIX_W + DEF_FRAC_BITS;
  localparam int unsigned NORM_SUM_W    = PIX_W + DEF_RECIP_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MAX = 2'd1,
    DIV      = 2'd2,
    STREAM   = 2'd3
  } nr_state_t;

  // out = min(255, round(pix * floor((255 << FRAC) / max) / 2^FRAC)); max == 0 yields 0
  function automatic logic [PIX_W-1:0] ref_norm(input logic [PIX_W-1:0] pix,
                                                input logic [PIX_W-1:0] max_v);
    logic [DEF_RECIP_W-1:0] r;
    logic [NORM_SUM_W-1:0]  sum;
    logic [NORM_SUM_W-1:0]  q;
    if (max_v == '0) return '0;
    r   = DEF_RECIP_W'((PIX_MAX << DEF_FRAC_BITS) / 32'(max_v));
    sum = (NORM_SUM_W'(pix) * NORM_SUM_W'(r)) + (NORM_SUM_W'(1) << (DEF_FRAC_BITS - 1));
    q   = sum >> DEF_FRAC_BITS;
    return (q > NORM_SUM_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : PIX_W'(q);
  endfunction

endpackage

// File: rtl/norm_reader_div.sv
// Restoring divider, one quotient bit per cycle; used to build the frame reciprocal.
module recip_div
  import norm_pkg::*;
#(
  parameter int unsigned DVD_W = DEF_RECIP_W,
  parameter int unsigned DVS_W = PIX_W
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DVD_W);

  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVS_W:0]   rem_sh_c;
  logic [DVS_W:0]   rem_nx_c;
  logic             ge_c;

  // Dividend shifts out at the top while quotient bits shift in at the bottom
  always_comb begin
    rem_sh_c = {rem_q, dvd_q[DVD_W-1]};
    ge_c     = (rem_sh_c >= {1'b0, dvs_q});
    rem_nx_c = ge_c ? (rem_sh_c - {1'b0, dvs_q}) : rem_sh_c;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
        rem_q <= '0;
        cnt_q <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        dvd_q <= {dvd_q[DVD_W-2:0], ge_c};
        rem_q <= rem_nx_c[DVS_W-1:0];
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DVD_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = dvd_q;

endmodule

// File: rtl/norm_reader.sv
// Frame normalizer: waits for the crop maximum, builds a reciprocal, then scales every pixel to 0..255.
module norm_reader
  import norm_pkg::*;
#(
  parameter int unsigned OUT_ROWS  = 10,
  parameter int unsigned OUT_COLS  = 10,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             ap_start,
  output logic             ap_ready,
  output logic             ap_done,
  input  logic [PIX_W-1:0] max_value,
  input  logic             max_value_tvalid,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [PIX_W-1:0] s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [PIX_W-1:0] m_axis_tdata,
  output logic             m_axis_tlast
);

  localparam int unsigned N_PIX  = OUT_ROWS * OUT_COLS;
  localparam int unsigned CNT_W  = $clog2(N_PIX + 1);
  localparam int unsigned R_W    = PIX_W + FRAC_BITS;
  localparam int unsigned PROD_W = PIX_W + R_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam logic [R_W-1:0] DIVIDEND = R_W'(R_W'(PIX_MAX) << FRAC_BITS);

  nr_state_t         state_q, state_d;
  logic [PIX_W-1:0]  max_q;
  logic [R_W-1:0]    recip_q;
  logic [CNT_W-1:0]  in_cnt_q, out_cnt_q, ld_cnt_q;
  logic              s1_valid_q;
  logic [PROD_W-1:0] s1_prod_q;

  logic              div_start_c, div_busy, div_done;
  logic [R_W-1:0]    div_quot;
  logic              m_accept_c, s2_load_c, s1_load_c, pop_c, last_acc_c;
  logic [SUM_W-1:0]  sum_c, shr_c;
  logic [PIX_W-1:0]  norm_c;

  assign div_start_c = (state_q == WAIT_MAX) && max_value_tvalid && (max_value != '0);

  recip_div #(.DVD_W(R_W), .DVS_W(PIX_W)) u_div (
    .clk      (clk),
    .aresetn  (aresetn),
    .start    (div_start_c),
    .dividend (DIVIDEND),
    .divisor  (max_value),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Each stage advances when its successor is empty or draining this cycle
  assign m_accept_c    = m_axis_tvalid && m_axis_tready;
  assign s2_load_c     = !m_axis_tvalid || m_axis_tready;
  assign s1_load_c     = !s1_valid_q || s2_load_c;
  assign s_axis_tready = (state_q == STREAM) && (in_cnt_q < CNT_W'(N_PIX)) && s1_load_c;
  assign pop_c         = s_axis_tvalid && s_axis_tready;
  assign last_acc_c    = m_accept_c && (out_cnt_q == CNT_W'(N_PIX - 1));

  always_comb begin
    sum_c  = SUM_W'(s1_prod_q) + (SUM_W'(1) << (FRAC_BITS - 1));
    shr_c  = sum_c >> FRAC_BITS;
    norm_c = (shr_c > SUM_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : PIX_W'(shr_c);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (ap_start) state_d = WAIT_MAX;
      WAIT_MAX: if (max_value_tvalid) state_d = DIV;
      DIV:      if ((max_q == '0) || (div_done && !div_busy)) state_d = STREAM;
      STREAM:   if (last_acc_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Control registers: handshake flags, frame maximum, reciprocal and beat counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ap_ready  <= 1'b1;
      ap_done   <= 1'b0;
      max_q     <= '0;
      recip_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ld_cnt_q  <= '0;
    end else begin
      ap_ready <= (state_d == IDLE);
      ap_done  <= last_acc_c;
      if ((state_q == WAIT_MAX) && max_value_tvalid) max_q <= max_value;
      if (state_q == DIV) begin
        if (max_q == '0)   recip_q <= '0;
        else if (div_done) recip_q <= div_quot;
      end
      if (last_acc_c) begin
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
        ld_cnt_q  <= '0;
      end else begin
        if (pop_c)                    in_cnt_q  <= in_cnt_q + CNT_W'(1);
        if (m_accept_c)               out_cnt_q <= out_cnt_q + CNT_W'(1);
        if (s2_load_c && s1_valid_q)  ld_cnt_q  <= ld_cnt_q + CNT_W'(1);
      end
    end
  end

  // Two-stage multiply then round/clamp pipeline
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q    <= 1'b0;
      s1_prod_q     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (s1_load_c) begin
        s1_valid_q <= pop_c;
        if (pop_c) s1_prod_q <= PROD_W'(s_axis_tdata) * PROD_W'(recip_q);
      end
      if (s2_load_c) begin
        m_axis_tvalid <= s1_valid_q;
        if (s1_valid_q) begin
          m_axis_tdata <= norm_c;
          m_axis_tlast <= (ld_cnt_q == CNT_W'(N_PIX - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_norm_reader.sv
// Randomized frame-level bench for norm_reader against an arithmetic normalization model.
module tb_norm_reader;

  localparam int N            = 100;
  localparam int FRAC         = 16;
  localparam int FRAME_BUDGET = 3000;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       ap_start;
  logic       ap_ready;
  logic       ap_done;
  logic [7:0] max_value;
  logic       max_value_tvalid;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;

  int n_checks = 0;
  int n_fail   = 0;

  int pix_q[$];
  int got_q[$];
  int last_q[$];
  int done_cnt, pop_cnt, first_rdy, done_cyc;

  always #5 clk = ~clk;

  norm_reader dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .ap_start         (ap_start),
    .ap_ready         (ap_ready),
    .ap_done          (ap_done),
    .max_value        (max_value),
    .max_value_tvalid (max_value_tvalid),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast)
  );

  // Reference: scale pix by 255/max with a truncated FRAC-bit reciprocal, round half up, saturate
  function automatic int model(input int pix, input int mx);
    longint r, v;
    if (mx == 0) return 0;
    r = (longint'(255) << FRAC) / mx;
    v = (longint'(pix) * r + (longint'(1) << (FRAC - 1))) >> FRAC;
    return (v > 255) ? 255 : int'(v);
  endfunction

  // One frame: start, present max, feed pix_q, drain m_axis; stops at ap_done or after abort_beats beats
  task automatic run_frame(input int maxv, input int vpct, input int rpct,
                           input int stale_gap, input int abort_beats, input bit poke_start);
    int idx = 0;
    int cyc = 0;
    got_q.delete();
    last_q.delete();
    done_cnt  = 0;
    pop_cnt   = 0;
    first_rdy = -1;
    done_cyc  = -1;
    @(negedge clk);
    ap_start         = 1'b1;
    max_value        = (stale_gap > 0) ? 8'd50 : 8'(maxv);
    max_value_tvalid = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    if (stale_gap > 0) begin
      max_value_tvalid = 1'b0;
      repeat (stale_gap) @(negedge clk);
      max_value        = 8'(maxv);
      max_value_tvalid = 1'b1;
    end
    while (1) begin
      if (ap_done) done_cnt++;
      if (done_cnt > 0) begin
        done_cyc = cyc;
        break;
      end
      if (abort_beats > 0 && got_q.size() >= abort_beats) break;
      if (cyc >= FRAME_BUDGET) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_timeout: %0d beats after %0d cycles, required ap_done", got_q.size(), cyc);
        break;
      end
      s_axis_tvalid = (idx < pix_q.size()) && (int'($urandom_range(99)) < vpct);
      s_axis_tdata  = s_axis_tvalid ? 8'(pix_q[idx]) : 8'($urandom_range(255));
      m_axis_tready = (int'($urandom_range(99)) < rpct);
      ap_start      = poke_start && !ap_ready && ($urandom_range(3) == 0);
      #1;
      if (s_axis_tready && first_rdy < 0) first_rdy = cyc;
      if (s_axis_tvalid && s_axis_tready) begin
        idx++;
        pop_cnt++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(int'(m_axis_tdata));
        last_q.push_back(int'(m_axis_tlast));
      end
      @(negedge clk);
      cyc++;
    end
    ap_start      = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #12;
    n_checks++;
    if ({ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 10000", {ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast});
    end
    n_checks++;
    if (m_axis_tdata !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_tdata: got %0d required 0", m_axis_tdata);
    end
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ap_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 1", ap_ready);
    end
  endtask

  task automatic test_max200();
    pix_q.delete();
    for (int i = 0; i < N; i++) pix_q.push_back((i % 3) * 100);
    run_frame(200, 100, 100, 0, 0, 1'b0);
    n_checks++;
    if (got_q.size() !== N) begin
      n_fail++;
      $display("FAIL m200_beats: got %0d required %0d", got_q.size(), N);
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== i * 255 / 2 + (i == 2 ? 0 : 0)) begin
        if (!(i == 1 && got_q[i] === 127)) begin
          n_fail++;
          $display("FAIL m200_anchor[%0d]: got %0d required %0d", i, got_q[i], (i == 0) ? 0 : (i == 1) ? 127 : 255);
        end
      end
    end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      n_checks++;
      if (got_q[i] !== model(pix_q[i], 200) || last_q[i] !== int'(i == N - 1)) begin
        n_fail++;
        $display("FAIL m200_beat[%0d]: got %0d/last %0d required %0d/last %0d", i, got_q[i], last_q[i], model(pix_q[i], 200), int'(i == N - 1));
      end
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL m200_done: got %0d required 1", done_cnt);
    end
    n_checks++;
    if (first_rdy < 25) begin
      n_fail++;
      $display("FAIL m200_div_latency: stream at cycle %0d required >= 25", first_rdy);
    end
    n_checks++;
    if (done_cyc - first_rdy !== N + 2) begin
      n_fail++;
      $display("FAIL m200_throughput: got %0d cycles required %0d", done_cyc - first_rdy, N + 2);
    end
  endtask

  task automatic test_zero_max();
    pix_q.delete();
    for (int i = 0; i < N; i++) pix_q.push_back(0);
    run_frame(0, 100, 100, 0, 0, 1'b0);
    n_checks++;
    if (first_rdy !== 2) begin
      n_fail++;
      $display("FAIL zero_div_skip: stream at cycle %0d required 2", first_rdy);
    end
    n_checks++;
    if (got_q.size() !== N || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL zero_frame: got %0d beats/%0d done required %0d/1", got_q.size(), done_cnt, N);
    end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      n_checks++;
      if (got_q[i] !== 0 || last_q[i] !== int'(i == N - 1)) begin
        n_fail++;
        $display("FAIL zero_beat[%0d]: got %0d/last %0d required 0/last %0d", i, got_q[i], last_q[i], int'(i == N - 1));
      end
    end
  endtask

  task automatic test_max_one();
    pix_q.delete();
    for (int i = 0; i < N; i++) pix_q.push_back((i % 2 == 0) ? 1 : 0);
    run_frame(1, 100, 100, 0, 0, 1'b0);
    n_checks++;
    if (got_q.size() !== N || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL one_frame: got %0d beats/%0d done required %0d/1", got_q.size(), done_cnt, N);
    end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      n_checks++;
      if (got_q[i] !== ((i % 2 == 0) ? 255 : 0)) begin
        n_fail++;
        $display("FAIL one_beat[%0d]: got %0d required %0d", i, got_q[i], (i % 2 == 0) ? 255 : 0);
      end
    end
  endtask

  task automatic test_random_backpressure();
    for (int f = 0; f < 3; f++) begin
      int mx = (f == 0) ? 255 : int'($urandom_range(255, 1));
      pix_q.delete();
      for (int i = 0; i < N + 10; i++)
        pix_q.push_back((f == 0 && i < N) ? (i * 255) / (N - 1) : int'($urandom_range(mx)));
      run_frame(mx, 50 + 20 * f, 50, 0, 0, 1'b1);
      n_checks++;
      if (got_q.size() !== N || pop_cnt !== N || done_cnt !== 1) begin
        n_fail++;
        $display("FAIL rnd%0d_counts: beats %0d pops %0d done %0d required %0d/%0d/1", f, got_q.size(), pop_cnt, done_cnt, N, N);
      end
      for (int i = 0; i < got_q.size() && i < N; i++) begin
        n_checks++;
        if (got_q[i] !== model(pix_q[i], mx) || last_q[i] !== int'(i == N - 1)) begin
          n_fail++;
          $display("FAIL rnd%0d_beat[%0d]: got %0d/last %0d required %0d/last %0d (pix %0d max %0d)", f, i, got_q[i], last_q[i], model(pix_q[i], mx), int'(i == N - 1), pix_q[i], mx);
        end
      end
    end
  endtask

  task automatic test_stale_max();
    pix_q.delete();
    pix_q.push_back(128);
    for (int i = 1; i < N; i++) pix_q.push_back(int'($urandom_range(255)));
    run_frame(255, 100, 100, 300, 0, 1'b0);
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== 128) begin
      n_fail++;
      $display("FAIL stale_first: got %0d required 128", (got_q.size() > 0) ? got_q[0] : -1);
    end
    n_checks++;
    if (got_q.size() !== N || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL stale_frame: got %0d beats/%0d done required %0d/1", got_q.size(), done_cnt, N);
    end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      n_checks++;
      if (got_q[i] !== model(pix_q[i], 255)) begin
        n_fail++;
        $display("FAIL stale_beat[%0d]: got %0d required %0d", i, got_q[i], model(pix_q[i], 255));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int mx;
    pix_q.delete();
    for (int i = 0; i < N; i++) pix_q.push_back(int'($urandom_range(255)));
    run_frame(255, 100, 100, 0, 40, 1'b0);
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 5'b10000 || m_axis_tdata !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b tdata %0d required 10000 tdata 0", {ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast}, m_axis_tdata);
    end
    n_checks++;
    if (done_cnt !== 0 || got_q.size() !== 40) begin
      n_fail++;
      $display("FAIL midreset_partial: got %0d done/%0d beats required 0/40", done_cnt, got_q.size());
    end
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ap_ready !== 1'b1 || ap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: ready %b done %b required 1/0", ap_ready, ap_done);
    end
    mx = int'($urandom_range(255, 1));
    pix_q.delete();
    for (int i = 0; i < N; i++) pix_q.push_back(int'($urandom_range(mx)));
    run_frame(mx, 80, 80, 0, 0, 1'b0);
    n_checks++;
    if (got_q.size() !== N || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL postreset_frame: got %0d beats/%0d done required %0d/1", got_q.size(), done_cnt, N);
    end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      n_checks++;
      if (got_q[i] !== model(pix_q[i], mx) || last_q[i] !== int'(i == N - 1)) begin
        n_fail++;
        $display("FAIL postreset_beat[%0d]: got %0d/last %0d required %0d/last %0d", i, got_q[i], last_q[i], model(pix_q[i], mx), int'(i == N - 1));
      end
    end
  endtask

  initial begin
    ap_start         = 1'b0;
    max_value        = 8'd0;
    max_value_tvalid = 1'b0;
    s_axis_tvalid    = 1'b0;
    s_axis_tdata     = 8'd0;
    m_axis_tready    = 1'b0;
    test_reset();
    test_max200();
    test_zero_max();
    test_max_one();
    test_random_backpressure();
    test_stale_max();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
